// File: rtl/ee354_dialer_pkg.sv
// Shared types and sizing helpers for the U/Z code dialer.
// Optional DIALER_RETRY_EN adds the RECOVER state used for a single automatic retry.
package ee354_dialer_pkg;

`ifdef DIALER_RETRY_EN
  localparam int unsigned N_STATES = 7;
`else
  localparam int unsigned N_STATES = 6;
`endif

  typedef enum logic [N_STATES-1:0] {
    S_IDLE      = N_STATES'(1 << 0),
    S_PRESS     = N_STATES'(1 << 1),
    S_GAP       = N_STATES'(1 << 2),
    S_WAITRESP  = N_STATES'(1 << 3),
    S_DONE_OK   = N_STATES'(1 << 4),
    S_DONE_FAIL = N_STATES'(1 << 5)
`ifdef DIALER_RETRY_EN
    ,
    S_RECOVER   = N_STATES'(1 << 6)
`endif
  } state_e;

  // Result register layout is {success, fail}
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b10;
  localparam logic [1:0] RES_FAIL = 2'b01;

  function automatic int unsigned timer_width(input int unsigned h, input int unsigned g,
                                              input int unsigned r);
    int unsigned m;
    m = h;
    if (g > m) m = g;
    if (r > m) m = r;
    return (m < 2) ? 1 : int'($clog2(m + 1));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/ee354_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ee354_cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ee354_code_dialer.sv
// Plays a stored code as timed U/Z button pulses into the number lock and reports the outcome.
// Define DIALER_RETRY_EN to re-send the captured code once after the first failure.
module ee354_code_dialer #(
  parameter int unsigned CODE_LEN = 4,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned RESP_TO  = 16
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                opening,
  input  logic                bad,
  output logic                U,
  output logic                Z,
  output logic                busy,
  output logic                done,
  output logic                success,
  output logic                fail
);
  import ee354_dialer_pkg::*;

  localparam int unsigned TW = timer_width(HOLD_CYC, GAP_CYC, RESP_TO);
  localparam int unsigned IW = idx_width(CODE_LEN);

  state_e              state_q, state_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          result_q, result_d;
  logic                u_q, u_d, z_q, z_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                tmr_load_c, tmr_expired, fail_c;
  logic [TW-1:0]       tmr_val_c;
`ifdef DIALER_RETRY_EN
  logic                retry_q, retry_d;
`endif

  ee354_cycle_timer #(.W(TW)) u_timer (
    .clk     (Clk),
    .rst     (reset),
    .load    (tmr_load_c),
    .value   (tmr_val_c),
    .expired (tmr_expired)
  );

  // Next state, timer reloads and next registered outputs
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    result_d   = result_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    fail_c     = 1'b0;
`ifdef DIALER_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d     = code;
          result_d   = RES_NONE;
          idx_d      = IW'(CODE_LEN - 1);
          state_d    = S_PRESS;
          tmr_load_c = 1'b1;
          tmr_val_c  = TW'(HOLD_CYC - 1);
`ifdef DIALER_RETRY_EN
          retry_d    = 1'b0;
`endif
        end
      end
      S_PRESS: begin
        if (bad) begin
          fail_c = 1'b1;
        end else if (tmr_expired) begin
          state_d    = S_GAP;
          tmr_load_c = 1'b1;
          tmr_val_c  = TW'(GAP_CYC - 1);
        end
      end
      S_GAP: begin
        if (bad) begin
          fail_c = 1'b1;
        end else if (tmr_expired) begin
          tmr_load_c = 1'b1;
          if (idx_q != '0) begin
            idx_d     = idx_q - IW'(1);
            state_d   = S_PRESS;
            tmr_val_c = TW'(HOLD_CYC - 1);
          end else begin
            state_d   = S_WAITRESP;
            tmr_val_c = TW'(RESP_TO - 1);
          end
        end
      end
      S_WAITRESP: begin
        if (opening) begin
          state_d  = S_DONE_OK;
          result_d = RES_OK;
        end else if (bad || tmr_expired) begin
          fail_c = 1'b1;
        end
      end
`ifdef DIALER_RETRY_EN
      // Hold off until the lock leaves BAD, then one gap before re-sending from the MSB
      S_RECOVER: begin
        if (bad) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = TW'(GAP_CYC - 1);
        end else if (tmr_expired) begin
          idx_d      = IW'(CODE_LEN - 1);
          state_d    = S_PRESS;
          tmr_load_c = 1'b1;
          tmr_val_c  = TW'(HOLD_CYC - 1);
        end
      end
`endif
      S_DONE_OK, S_DONE_FAIL: state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase

    if (fail_c) begin
`ifdef DIALER_RETRY_EN
      if (!retry_q) begin
        retry_d    = 1'b1;
        state_d    = S_RECOVER;
        tmr_load_c = 1'b1;
        tmr_val_c  = TW'(GAP_CYC - 1);
      end else begin
        state_d  = S_DONE_FAIL;
        result_d = RES_FAIL;
      end
`else
      state_d  = S_DONE_FAIL;
      result_d = RES_FAIL;
`endif
    end

    u_d    = (state_d == S_PRESS) &&  code_d[idx_d];
    z_d    = (state_d == S_PRESS) && !code_d[idx_d];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE_OK) || (state_d == S_DONE_FAIL);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      result_q <= RES_NONE;
      u_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DIALER_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      u_q      <= u_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DIALER_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign U                 = u_q;
  assign Z                 = z_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign {success, fail}   = result_q;

endmodule

// File: tb/tb_ee354_code_dialer.sv
// Scoreboard bench for ee354_code_dialer: expected pulses and results are queued at stimulus time.
module tb_ee354_code_dialer;

  localparam int unsigned CL = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned G  = 4;
  localparam int unsigned RT = 16;

  logic          Clk = 1'b0;
  logic          reset, start, opening, bad;
  logic [CL-1:0] code;
  logic          U, Z, busy, done, success, fail;

  ee354_code_dialer #(.CODE_LEN(CL), .HOLD_CYC(H), .GAP_CYC(G), .RESP_TO(RT)) dut (
    .Clk(Clk), .reset(reset), .start(start), .code(code), .opening(opening), .bad(bad),
    .U(U), .Z(Z), .busy(busy), .done(done), .success(success), .fail(fail)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic b; int len; } pulse_t;
  typedef struct { logic ok; int cyc; } res_t;

  pulse_t pq[$];
  res_t   rq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     both_cnt = 0;
  logic   in_pulse = 1'b0;
  logic   pbit = 1'b0;
  int     plen = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Output monitor: measures U/Z pulses and pops expectations on done
  always @(negedge Clk or posedge reset) begin
    if (reset) begin
      in_pulse = 1'b0;
      plen     = 0;
    end else begin
      if (U === 1'b1 && Z === 1'b1) both_cnt++;
      if (U === 1'b1 || Z === 1'b1) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          pbit     = U;
          plen     = 0;
        end
        plen++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (pq.size() == 0) begin
          check("pulse_extra", 32'd1, 32'd0);
        end else begin
          pulse_t p;
          p = pq.pop_front();
          check("pulse_bit", 32'(pbit), 32'(p.b));
          check("pulse_len", 32'(plen), 32'(p.len));
        end
      end
      if (done === 1'b1) begin
        if (rq.size() == 0) begin
          check("done_extra", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = rq.pop_front();
          check("done_cyc", 32'(cyc), 32'(r.cyc));
          check("success", 32'(success), 32'(r.ok));
          check("fail", 32'(fail), 32'(!r.ok));
        end
      end
    end
  end

  task automatic push_code(input logic [CL-1:0] c);
    logic [CL-1:0] v;
    v = c;
    for (int i = CL - 1; i >= 0; i--) pq.push_back('{v[i], int'(H)});
  endtask

  task automatic push_res(input logic ok, input int at);
    rq.push_back('{ok, at});
  endtask

  // Drives a one-cycle start; e is the cycle count seen at the next negedge
  task automatic go(input logic [CL-1:0] c, output int e);
    @(negedge Clk);
    code  = c;
    start = 1'b1;
    e     = cyc + 1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e;
    reset = 1'b0; start = 1'b0; opening = 1'b0; bad = 1'b0; code = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_u", 32'(U), 32'd0);
    check("rst_z", 32'(Z), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'({success, fail}), 32'd0);
    repeat (3) @(negedge Clk);
    reset = 1'b0;

    // Code 1011, lock opens in the third WAITRESP cycle
    go(4'b1011, e);
    push_code(4'b1011);
    push_res(1'b1, e + 35);
    wait_to(e + 1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_u_msb", 32'(U), 32'd1);
    wait_to(e + 34);
    opening = 1'b1;
    @(negedge Clk);
    opening = 1'b0;
    wait_to(e + 40);
    check("t1_pending", 32'(rq.size()), 32'd0);
    check("t1_hold", 32'(success), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // Code 1011, lock silent: response timeout
    go(4'b1011, e);
    check("t2_clear", 32'(success), 32'd0);
    push_code(4'b1011);
`ifdef DIALER_RETRY_EN
    push_code(4'b1011);
    push_res(1'b0, e + 100);
    wait_to(e + 106);
`else
    push_res(1'b0, e + 48);
    wait_to(e + 54);
`endif
    check("t2_pending", 32'(rq.size()), 32'd0);
    check("t2_hold", 32'(fail), 32'd1);

`ifndef DIALER_RETRY_EN
    // Code 1101, bad during the gap after bit 1: bit 0 never sent
    go(4'b1101, e);
    pq.push_back('{1'b1, int'(H)});
    pq.push_back('{1'b1, int'(H)});
    pq.push_back('{1'b0, int'(H)});
    push_res(1'b0, e + 22);
    wait_to(e + 21);
    bad = 1'b1;
    @(negedge Clk);
    bad = 1'b0;
    check("t3_u", 32'(U), 32'd0);
    check("t3_z", 32'(Z), 32'd0);
    wait_to(e + 40);
    check("t3_pending", 32'(rq.size()), 32'd0);

    // Code 1101, bad mid-PRESS of bit 2: U drops the next cycle
    go(4'b1101, e);
    pq.push_back('{1'b1, int'(H)});
    pq.push_back('{1'b1, 2});
    push_res(1'b0, e + 10);
    wait_to(e + 9);
    bad = 1'b1;
    @(negedge Clk);
    bad = 1'b0;
    check("t3b_u", 32'(U), 32'd0);
    wait_to(e + 20);
    check("t3b_pending", 32'(rq.size()), 32'd0);
`endif

    // Reset mid-PRESS, then a full resend from the MSB
    go(4'b1000, e);
    wait_to(e + 1);
    #2 reset = 1'b1;
    #1;
    check("t4_u", 32'(U), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    pq.delete();
    rq.delete();
    @(negedge Clk);
    #2 reset = 1'b0;
    go(4'b1000, e);
    push_code(4'b1000);
    push_res(1'b1, e + 35);
    wait_to(e + 34);
    opening = 1'b1;
    @(negedge Clk);
    opening = 1'b0;
    wait_to(e + 40);
    check("t4_pending", 32'(rq.size()), 32'd0);

`ifndef DIALER_RETRY_EN
    // start held for 40 cycles gives one sequence; start in the DONE cycle is ignored
    @(negedge Clk);
    code  = 4'b1011;
    start = 1'b1;
    e     = cyc + 1;
    push_code(4'b1011);
    push_res(1'b0, e + 48);
    wait_to(e + 39);
    start = 1'b0;
    wait_to(e + 48);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_to(e + 60);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_pending", 32'(rq.size()), 32'd0);
`endif

`ifdef DIALER_RETRY_EN
    // First attempt answered with bad, retry opens the lock
    go(4'b1011, e);
    push_code(4'b1011);
    push_code(4'b1011);
    push_res(1'b1, e + 74);
    wait_to(e + 33);
    bad = 1'b1;
    wait_to(e + 35);
    bad = 1'b0;
    wait_to(e + 73);
    opening = 1'b1;
    @(negedge Clk);
    opening = 1'b0;
    wait_to(e + 80);
    check("t6_pending", 32'(rq.size()), 32'd0);
    check("t6_success", 32'(success), 32'd1);
`endif

    repeat (5) @(negedge Clk);
    check("pulses_left", 32'(pq.size()), 32'd0);
    check("uz_both", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
